// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and 32-entry architectural register file.
// Selects the write-back value from the MEM/WB bundle, commits it to the
// register file, serves two combinational read ports with optional
// same-cycle write-through bypass, and counts committed writes.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [0:1]        wb_control,
  input  logic [DATA_W-1:0] wb_mem_data,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic [31:0]       wr_count
);

  localparam int DEPTH = 1 << ADDR_W;

  // wb_control uses MSB-first indexing: [0] = RegWrite, [1] = MemToReg
  logic                reg_write_s;
  logic                mem_to_reg_s;
  logic [DATA_W-1:0]   regs_q [DEPTH];
  logic [31:0]         wr_count_q;
  logic [31:0]         wr_count_d;
  logic [DATA_W-1:0]   rs_data_s;
  logic [DATA_W-1:0]   rt_data_s;

  assign reg_write_s  = wb_control[0];
  assign mem_to_reg_s = wb_control[1];

  // Write-back value selection and effective write enable (reset drops the write)
  always_comb begin
    wb_data = wb_alu_result;
    if (mem_to_reg_s) begin
      wb_data = wb_mem_data;
    end else begin
      wb_data = wb_alu_result;
    end
    wb_we = reg_write_s & (wb_rd != {ADDR_W{1'b0}}) & ~rst;
  end

  // Commit counter next state; wraps naturally at 32 bits
  always_comb begin
    wr_count_d = wr_count_q;
    if (wb_we) begin
      wr_count_d = wr_count_q + 32'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
  end

  // Register file storage: synchronous clear on reset, single write port otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else if (wb_we) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  // Committed-write counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_q <= 32'd0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  // Read port A: zero register, then bypass on address match, then storage
  always_comb begin
    rs_data_s = {DATA_W{1'b0}};
    if (rs_addr == {ADDR_W{1'b0}}) begin
      rs_data_s = {DATA_W{1'b0}};
    end else if (BYPASS && wb_we && (rs_addr == wb_rd)) begin
      rs_data_s = wb_data;
    end else begin
      rs_data_s = regs_q[rs_addr];
    end
  end

  // Read port B: same priority as port A, evaluated independently
  always_comb begin
    rt_data_s = {DATA_W{1'b0}};
    if (rt_addr == {ADDR_W{1'b0}}) begin
      rt_data_s = {DATA_W{1'b0}};
    end else if (BYPASS && wb_we && (rt_addr == wb_rd)) begin
      rt_data_s = wb_data;
    end else begin
      rt_data_s = regs_q[rt_addr];
    end
  end

  assign rs_data  = rs_data_s;
  assign rt_data  = rt_data_s;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile: table-driven directed vectors on a BYPASS=1
// instance plus hand-written sequences for reset readout and a BYPASS=0 instance.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [0:1]  wb_control;
  logic [31:0] wb_mem_data;
  logic [31:0] wb_alu_result;
  logic [4:0]  wb_rd;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data, rt_data, wb_data, wr_count;
  logic        wb_we;
  logic [31:0] nb_rs_data, nb_rt_data, nb_wb_data, nb_wr_count;
  logic        nb_wb_we;

  int errors = 0;
  int checks = 0;

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .wb_control(wb_control), .wb_mem_data(wb_mem_data),
    .wb_alu_result(wb_alu_result), .wb_rd(wb_rd), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .wb_data(wb_data), .wb_we(wb_we),
    .wr_count(wr_count)
  );

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .wb_control(wb_control), .wb_mem_data(wb_mem_data),
    .wb_alu_result(wb_alu_result), .wb_rd(wb_rd), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(nb_rs_data), .rt_data(nb_rt_data), .wb_data(nb_wb_data), .wb_we(nb_wb_we),
    .wr_count(nb_wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  ctrl;   // {RegWrite, MemToReg} in wb_control order
    logic [31:0] mem;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic [31:0] e_wb;
    logic        e_we;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    //        rst   ctrl   mem            alu            rd     rs     rt     e_rs           e_rt           e_wb           we    cnt
    vecs[0]  = '{1'b0, 2'b10, 32'hDEAD_BEEF, 32'h1234_5678, 5'd5,  5'd5,  5'd0,  32'h1234_5678, 32'h0,         32'h1234_5678, 1'b1, 32'd0};
    vecs[1]  = '{1'b0, 2'b00, 32'h0,         32'h0,         5'd5,  5'd5,  5'd5,  32'h1234_5678, 32'h1234_5678, 32'h0,         1'b0, 32'd1};
    vecs[2]  = '{1'b0, 2'b11, 32'hCAFE_F00D, 32'h1111_1111, 5'd9,  5'd9,  5'd9,  32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 32'd1};
    vecs[3]  = '{1'b0, 2'b00, 32'h0,         32'h0,         5'd9,  5'd9,  5'd5,  32'hCAFE_F00D, 32'h1234_5678, 32'h0,         1'b0, 32'd2};
    vecs[4]  = '{1'b0, 2'b11, 32'hFFFF_FFFF, 32'h0,         5'd0,  5'd0,  5'd9,  32'h0,         32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b0, 32'd2};
    vecs[5]  = '{1'b0, 2'b01, 32'h0BAD_F00D, 32'h0000_0077, 5'd3,  5'd3,  5'd0,  32'h0,         32'h0,         32'h0BAD_F00D, 1'b0, 32'd2};
    vecs[6]  = '{1'b0, 2'b00, 32'h0,         32'h0,         5'd3,  5'd3,  5'd0,  32'h0,         32'h0,         32'h0,         1'b0, 32'd2};
    vecs[7]  = '{1'b0, 2'b10, 32'h0,         32'hAAAA_0000, 5'd7,  5'd7,  5'd7,  32'hAAAA_0000, 32'hAAAA_0000, 32'hAAAA_0000, 1'b1, 32'd2};
    vecs[8]  = '{1'b0, 2'b00, 32'h0,         32'h0,         5'd7,  5'd7,  5'd9,  32'hAAAA_0000, 32'hCAFE_F00D, 32'h0,         1'b0, 32'd3};
    vecs[9]  = '{1'b1, 2'b11, 32'h5555_5555, 32'h0,         5'd7,  5'd7,  5'd7,  32'hAAAA_0000, 32'hAAAA_0000, 32'h5555_5555, 1'b0, 32'd3};
    vecs[10] = '{1'b0, 2'b00, 32'h0,         32'h0,         5'd7,  5'd7,  5'd5,  32'h0,         32'h0,         32'h0,         1'b0, 32'd0};
    vecs[11] = '{1'b0, 2'b10, 32'h0,         32'hFFFF_FFFF, 5'd31, 5'd31, 5'd30, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, 1'b1, 32'd0};
    vecs[12] = '{1'b0, 2'b00, 32'h0,         32'h0,         5'd31, 5'd31, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b0, 32'd1};

    // Reset
    rst = 1'b1; wb_control = 2'b00; wb_mem_data = 32'h0; wb_alu_result = 32'h0;
    wb_rd = 5'd0; rs_addr = 5'd0; rt_addr = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_wr_count", wr_count, 32'd0);
    chk("reset_wb_we", {31'd0, wb_we}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      rs_addr = i[4:0];
      rt_addr = 5'd31 - i[4:0];
      #1;
      chk($sformatf("reset_rs[%0d]", i), rs_data, 32'h0);
      chk($sformatf("reset_rt[%0d]", 31 - i), rt_data, 32'h0);
    end

    // Table-driven vectors, one per clock cycle
    @(posedge clk);
    #1;
    for (int v = 0; v < 13; v++) begin
      rst = vecs[v].rst;
      wb_control = vecs[v].ctrl;
      wb_mem_data = vecs[v].mem;
      wb_alu_result = vecs[v].alu;
      wb_rd = vecs[v].rd;
      rs_addr = vecs[v].rs;
      rt_addr = vecs[v].rt;
      #2;
      chk($sformatf("v%0d_rs_data", v), rs_data, vecs[v].e_rs);
      chk($sformatf("v%0d_rt_data", v), rt_data, vecs[v].e_rt);
      chk($sformatf("v%0d_wb_data", v), wb_data, vecs[v].e_wb);
      chk($sformatf("v%0d_wb_we", v), {31'd0, wb_we}, {31'd0, vecs[v].e_we});
      chk($sformatf("v%0d_wr_count", v), wr_count, vecs[v].e_cnt);
      @(posedge clk);
      #1;
    end

    // No-bypass instance: write reg 4 and read it in the same cycle
    rst = 1'b0; wb_control = 2'b10; wb_alu_result = 32'h0000_0042; wb_mem_data = 32'h0;
    wb_rd = 5'd4; rs_addr = 5'd4; rt_addr = 5'd4;
    #2;
    chk("nb_same_cycle_rs", nb_rs_data, 32'h0);
    chk("nb_same_cycle_rt", nb_rt_data, 32'h0);
    chk("nb_wb_we", {31'd0, nb_wb_we}, 32'd1);
    chk("byp_same_cycle_rs", rs_data, 32'h0000_0042);
    @(posedge clk);
    #1;
    wb_control = 2'b00; wb_alu_result = 32'h0;
    #1;
    chk("nb_next_cycle_rs", nb_rs_data, 32'h0000_0042);
    chk("nb_next_cycle_rt", nb_rt_data, 32'h0000_0042);
    chk("nb_wr_count", nb_wr_count, 32'd2);
    chk("byp_wr_count", wr_count, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
